// File: rtl/program_memory.sv
// Loadable instruction memory: one-cycle fetch port, streaming load port,
// and a clear sequencer that zeroes the array after every reset.
module program_memory #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    output logic              ready,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SUM_W = ADDR_W + 2;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;

    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                fetch_valid_d;
    logic [DATA_W-1:0]   fetch_instr_d;
    logic                fetch_err_d;
    logic                load_done_d;
    logic                load_err_d;

    // State, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= '0;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_err   <= 1'b0;
            ready       <= 1'b0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            fetch_valid <= fetch_valid_d;
            fetch_instr <= fetch_instr_d;
            fetch_err   <= fetch_err_d;
            ready       <= (state_d == IDLE);
            load_ready  <= (state_d == LOAD);
            load_done   <= load_done_d;
            load_err    <= load_err_d;
        end
    end

    // Storage array; contents are initialised by the clear sequencer, not by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state, write port and fetch/load response logic
    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        remaining_d   = remaining_q;
        mem_we        = 1'b0;
        mem_waddr     = '0;
        mem_wdata     = '0;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr;
        fetch_err_d   = fetch_err;
        load_done_d   = 1'b0;
        load_err_d    = 1'b0;

        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = IDX_W'(clr_ptr_q);
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    clr_ptr_d = '0;
                    state_d   = IDLE;
                end
            end

            IDLE: begin
                // Fetch reads the array before any write of a simultaneously started load
                if (fetch_req) begin
                    fetch_valid_d = 1'b1;
                    if ({1'b0, fetch_addr} < CNT_W'(DEPTH)) begin
                        fetch_instr_d = mem[IDX_W'(fetch_addr)];
                        fetch_err_d   = 1'b0;
                    end else begin
                        fetch_instr_d = '0;
                        fetch_err_d   = 1'b1;
                    end
                end
                if (load_start) begin
                    if (load_count == '0) begin
                        load_done_d = 1'b1;
                    end else if ((SUM_W'(load_base) + SUM_W'(load_count)) > SUM_W'(DEPTH)) begin
                        load_err_d = 1'b1;
                    end else begin
                        wr_ptr_d    = load_base;
                        remaining_d = load_count;
                        state_d     = LOAD;
                    end
                end
            end

            LOAD: begin
                if (load_valid) begin
                    mem_we      = 1'b1;
                    mem_waddr   = IDX_W'(wr_ptr_q);
                    mem_wdata   = load_data;
                    wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

            default: begin
                state_d = CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_program_memory.sv
// Randomised self-checking bench for program_memory with a behavioural model.
module tb_program_memory;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 200;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_err;
    logic              ready;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_count;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              load_err;

    int total = 0;
    int bad   = 0;

    program_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .ready(ready),
        .load_start(load_start), .load_base(load_base), .load_count(load_count),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: counts of words left to clear / load, plus a word array
    logic [DATA_W-1:0] m_mem [0:255];
    int                m_clear_left;
    bit                m_loading;
    logic [7:0]        m_ptr;
    int                m_left;
    logic              e_valid, e_err, e_ready, e_lready, e_done, e_lerr;
    logic [DATA_W-1:0] e_instr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear_left <= DEPTH;
            m_loading    <= 1'b0;
            m_ptr        <= 8'd0;
            m_left       <= 0;
            e_valid <= 1'b0; e_err <= 1'b0; e_instr <= '0;
            e_ready <= 1'b0; e_lready <= 1'b0; e_done <= 1'b0; e_lerr <= 1'b0;
        end else begin
            e_valid <= 1'b0;
            e_done  <= 1'b0;
            e_lerr  <= 1'b0;
            if (m_clear_left > 0) begin
                m_mem[8'(DEPTH - m_clear_left)] <= '0;
                m_clear_left <= m_clear_left - 1;
                e_ready      <= (m_clear_left == 1);
            end else if (m_loading) begin
                if (load_valid) begin
                    m_mem[m_ptr] <= load_data;
                    m_ptr        <= m_ptr + 8'd1;
                    m_left       <= m_left - 1;
                    if (m_left == 1) begin
                        m_loading <= 1'b0;
                        e_done    <= 1'b1;
                        e_ready   <= 1'b1;
                        e_lready  <= 1'b0;
                    end
                end
            end else begin
                if (fetch_req) begin
                    e_valid <= 1'b1;
                    if (int'(fetch_addr) < DEPTH) begin
                        e_instr <= m_mem[fetch_addr];
                        e_err   <= 1'b0;
                    end else begin
                        e_instr <= '0;
                        e_err   <= 1'b1;
                    end
                end
                if (load_start) begin
                    if (load_count == '0) begin
                        e_done <= 1'b1;
                    end else if (int'(load_base) + int'(load_count) > DEPTH) begin
                        e_lerr <= 1'b1;
                    end else begin
                        m_loading <= 1'b1;
                        m_ptr     <= load_base;
                        m_left    <= int'(load_count);
                        e_ready   <= 1'b0;
                        e_lready  <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", 32'(ready), 32'(e_ready));
            chk("load_ready", 32'(load_ready), 32'(e_lready));
            chk("load_done", 32'(load_done), 32'(e_done));
            chk("load_err", 32'(load_err), 32'(e_lerr));
            chk("fetch_valid", 32'(fetch_valid), 32'(e_valid));
            chk("fetch_instr", 32'(fetch_instr), 32'(e_instr));
            if (e_valid) chk("fetch_err", 32'(fetch_err), 32'(e_err));
        end
    end

    task automatic wait_clear(output int edges);
        edges = 0;
        while (!ready && edges < 1000) begin
            fetch_req  = 1'($urandom);
            fetch_addr = 8'($urandom);
            load_start = 1'($urandom);
            load_base  = 8'($urandom_range(0, 20));
            load_count = 9'($urandom_range(0, 5));
            @(negedge clk);
            edges++;
        end
        fetch_req  = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic do_fetch(input int a, input logic [15:0] ei, input logic ee, input string nm);
        fetch_req  = 1'b1;
        fetch_addr = 8'(a);
        @(negedge clk);
        fetch_req = 1'b0;
        chk({nm, " valid"}, 32'(fetch_valid), 32'd1);
        chk({nm, " instr"}, 32'(fetch_instr), 32'(ei));
        chk({nm, " err"}, 32'(fetch_err), 32'(ee));
    endtask

    task automatic start_load(input int base, input int cnt, input bit with_fetch, input int faddr);
        load_start = 1'b1;
        load_base  = 8'(base);
        load_count = 9'(cnt);
        fetch_req  = with_fetch;
        fetch_addr = 8'(faddr);
        @(negedge clk);
        load_start = 1'b0;
        fetch_req  = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input int gaps);
        repeat (gaps) begin
            load_valid = 1'b0;
            load_data  = 16'($urandom);
            fetch_req  = 1'($urandom);
            fetch_addr = 8'($urandom);
            @(negedge clk);
        end
        load_valid = 1'b1;
        load_data  = d;
        fetch_req  = 1'($urandom);
        @(negedge clk);
        load_valid = 1'b0;
        fetch_req  = 1'b0;
    endtask

    initial begin
        int edges;
        logic [15:0] last_word;
        int b, c;

        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        load_start = 1'b0; load_base = '0; load_count = '0;
        load_valid = 1'b0; load_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clear latency, with requests arriving throughout the clear
        wait_clear(edges);
        chk("clear edges", 32'(edges), 32'(DEPTH));
        do_fetch(0, 16'h0000, 1'b0, "clr0");
        do_fetch(14, 16'h0000, 1'b0, "clr14");
        do_fetch(DEPTH - 1, 16'h0000, 1'b0, "clrlast");

        // Three-word load with one valid gap and fetches attempted during LOAD
        start_load(10, 3, 1'b0, 0);
        chk("load_ready after start", 32'(load_ready), 32'd1);
        chk("ready during load", 32'(ready), 32'd0);
        send_beat(16'h0105, 0);
        send_beat(16'h020A, 1);
        send_beat(16'h1280, 0);
        chk("load3 done", 32'(load_done), 32'd1);
        chk("load3 ready", 32'(ready), 32'd1);
        fetch_req = 1'b1; fetch_addr = 8'd10;
        @(negedge clk);
        chk("b2b 10", 32'(fetch_instr), 32'h0105);
        fetch_addr = 8'd11;
        @(negedge clk);
        chk("b2b 11", 32'(fetch_instr), 32'h020A);
        fetch_addr = 8'd12;
        @(negedge clk);
        fetch_req = 1'b0;
        chk("b2b 12", 32'(fetch_instr), 32'h1280);
        chk("b2b 12 valid", 32'(fetch_valid), 32'd1);

        // Rejected and empty loads
        start_load(195, 8, 1'b0, 0);
        chk("overflow err", 32'(load_err), 32'd1);
        chk("overflow ready", 32'(ready), 32'd1);
        start_load(250, 8, 1'b0, 0);
        chk("base oor err", 32'(load_err), 32'd1);
        do_fetch(195, 16'h0000, 1'b0, "after reject");
        start_load(50, 0, 1'b0, 0);
        chk("empty done", 32'(load_done), 32'd1);
        chk("empty err", 32'(load_err), 32'd0);

        // Load that ends exactly at the top word
        start_load(DEPTH - 8, 8, 1'b0, 0);
        last_word = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            last_word = 16'($urandom);
            send_beat(last_word, $urandom_range(0, 1));
        end
        chk("boundary done", 32'(load_done), 32'd1);
        do_fetch(DEPTH - 1, last_word, 1'b0, "top word");
        do_fetch(210, 16'h0000, 1'b1, "oor210");
        do_fetch(255, 16'h0000, 1'b1, "oor255");

        // Fetch together with load_start returns pre-load contents
        start_load(10, 1, 1'b1, 10);
        chk("concurrent fetch", 32'(fetch_instr), 32'h0105);
        send_beat(16'hBEEF, 0);
        do_fetch(10, 16'hBEEF, 1'b0, "post overwrite");

        // Randomised traffic
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, 210);
                c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 256) : $urandom_range(0, 10);
                start_load(b, c, 1'($urandom), $urandom_range(0, 255));
                if (c != 0 && b + c <= DEPTH) begin
                    for (int k = 0; k < c; k++) send_beat(16'($urandom), $urandom_range(0, 2));
                end
            end else begin
                fetch_req  = ($urandom_range(0, 3) != 0);
                fetch_addr = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1));
                @(negedge clk);
                fetch_req = 1'b0;
            end
        end

        // Reset in the middle of a load
        start_load(20, 5, 1'b0, 0);
        send_beat(16'h1111, 0);
        send_beat(16'h2222, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst fetch_instr", 32'(fetch_instr), 32'd0);
        chk("rst fetch_err", 32'(fetch_err), 32'd0);
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst load_ready", 32'(load_ready), 32'd0);
        chk("rst load_done", 32'(load_done), 32'd0);
        chk("rst load_err", 32'(load_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_clear(edges);
        chk("reclear edges", 32'(edges), 32'(DEPTH));
        do_fetch(20, 16'h0000, 1'b0, "reclr20");
        do_fetch(21, 16'h0000, 1'b0, "reclr21");
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_memory.md
# program_memory

Parametrised, loadable instruction memory for the CPU fetch stage. It has a synchronous one-cycle fetch port and a streaming program-load port with valid/ready handshake. A built-in clear sequencer zeroes the whole array after reset, so no simulation-only initial contents are needed. While clearing or loading it reports not-ready and ignores fetches.

## Interface
- DATA_W, default 16: instruction width (opcode/reg1/reg2/imm format unchanged at 16).
- ADDR_W, default 8: fetch/load address width.
- DEPTH, default 256: implemented words; must be ≤ 2**ADDR_W; need not be a power of two.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request; accepted only when ready=1.
- fetch_addr  in  ADDR_W  word address of requested instruction.
- fetch_valid  out  1  high one cycle after an accepted fetch.
- fetch_instr  out  DATA_W  fetched word; holds its value when fetch_valid=0.
- fetch_err  out  1  qualifies fetch_valid; address ≥ DEPTH.
- ready  out  1  high in IDLE only.
- load_start  in  1  begin a load; sampled only in IDLE.
- load_base  in  ADDR_W  first address to write.
- load_count  in  ADDR_W+1  number of words to write.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  high in LOAD; a beat transfers when load_valid & load_ready.
- load_done  out  1  one-cycle pulse when a load completes.
- load_err  out  1  one-cycle pulse when load_start is rejected.

## Operation
- States: CLEAR, IDLE, LOAD. Reset enters CLEAR with clear pointer 0.
- CLEAR: writes 0 to address ptr each cycle, then increments ptr. After writing DEPTH-1, go to IDLE. load_start and fetch_req are ignored.
- IDLE: ready=1, load_ready=0.
- Fetch accepted when fetch_req & ready.
  - If fetch_addr < DEPTH: fetch_instr ← mem[fetch_addr], fetch_err ← 0.
  - Otherwise: fetch_instr ← 0 (NOP/LOADI R0,0 encoding), fetch_err ← 1.
- load_start in IDLE:
  - load_count = 0: load_done pulses next cycle. Stay in IDLE, no writes.
  - load_base + load_count > DEPTH (computed at ADDR_W+2 bits, no wrap): load_err pulses next cycle. Stay in IDLE, no writes.
  - Otherwise: latch wr_ptr ← load_base and remaining ← load_count, go to LOAD.
- LOAD: load_ready=1, ready=0.
  - Each transfer writes load_data to mem[wr_ptr], then wr_ptr++ and remaining--.
  - load_valid=0 cycles stall with no write.
  - The transfer with remaining=1 returns the FSM to IDLE and sets load_done for the following cycle.
- Simultaneous fetch_req and load_start in IDLE: both are accepted. The fetch returns pre-load contents.
- Fetches cannot overlap writes, so there is no read-during-write case.
- rst_n low at any time, including mid-LOAD: immediate return to CLEAR. All outputs go to reset values. Array contents are re-zeroed; partially loaded data is lost.

## Timing
- Reset values: fetch_valid=0, fetch_instr=0, fetch_err=0, ready=0, load_ready=0, load_done=0, load_err=0.
- Clear latency: first rising edge with rst_n high writes address 0. ready=1 on the cycle after the edge that writes DEPTH-1, i.e. DEPTH edges after reset release.
- Fetch latency 1: request sampled at edge N; fetch_valid, fetch_instr and fetch_err are registered at edge N and valid during cycle N+1. Throughput is one fetch per cycle.
- load_start sampled at edge N:
  - LOAD / load_ready=1 from cycle N+1; or
  - load_done/load_err high for cycle N+1 only.
- Last beat at edge M: load_ready=0, ready=1 and load_done=1 in cycle M+1. The first fetch can be issued in cycle M+1 and returns the new data in M+2.
- Minimum load duration is load_count cycles plus 1 start cycle.

## Test plan
- Reset clear (DEPTH=256): release rst_n → ready rises after exactly 256 edges. Fetch addresses 0, 14 and 255 → fetch_instr=0x0000, fetch_err=0, each with 1-cycle latency.
- Load and fetch: load_base=10, load_count=3, data 0x0105, 0x020A, 0x1280 with one load_valid gap → load_done one cycle after the last beat. Back-to-back fetch 10,11,12 → those words on consecutive cycles.
- Overflow reject: load_base=250, load_count=8 → load_err one cycle, ready stays 1, fetch 250 still returns 0x0000. load_count=0 → load_done, no writes.
- Out-of-range fetch (DEPTH=200, ADDR_W=8): fetch 210 → fetch_valid=1, fetch_err=1, fetch_instr=0. Fetch 199 → fetch_err=0.
- Fetch blocked: fetch_req during CLEAR and during LOAD → fetch_valid stays 0. fetch_req together with load_start in IDLE → old word returned.
- Reset mid-load: assert rst_n low after 2 of 5 beats at base 20 → outputs go to reset values immediately. After re-clear, fetch 20 and 21 return 0x0000.
